// File: rtl/fft_frame_loader_pkg.sv
// Shared types and constants for the fft_8pt frame loader.
package fft_pkg;
  localparam int NPT  = 8;
  localparam int DW   = 16;
  localparam int IDXW = 3;
  localparam logic [DW-1:0] Q_ONE = 16'h1000;

  typedef struct packed {
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
  } cplx_t;

  function automatic logic [IDXW-1:0] bitrev3(input logic [IDXW-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction
endpackage

// File: rtl/fft_frame_loader_if.sv
// Serial-in / frame-out handshake bundle between a sample source, the loader and fft_8pt.
interface fft_frame_loader_if;
  import fft_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           in_r;
  logic [DW-1:0]           in_i;
  logic                    in_mode;
  logic                    frame_abort;
  logic                    out_valid;
  logic                    out_ready;
  logic [NPT-1:0][DW-1:0]  out_r;
  logic [NPT-1:0][DW-1:0]  out_i;
  logic                    out_mode;
  logic [15:0]             frame_cnt;

  modport master (
    output in_valid, in_r, in_i, in_mode, frame_abort, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_mode, frame_cnt
  );

  modport slave (
    input  in_valid, in_r, in_i, in_mode, frame_abort, out_ready,
    output in_ready, out_valid, out_r, out_i, out_mode, frame_cnt
  );
endinterface

// File: rtl/fft_frame_loader_bank.sv
// One ping-pong bank: 8 complex entries, frame mode bit and full flag.
// FFT_FRAME_LOADER_BITREV_EN stores sample j at slot bitrev3(j).
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [IDXW-1:0]       wr_idx_i,
  input  cplx_t                 wr_data_i,
  input  logic                  wr_mode_i,
  input  logic                  wr_last_i,
  input  logic                  clr_i,
  output cplx_t [NPT-1:0]       data_o,
  output logic                  mode_o,
  output logic                  full_o
);
  cplx_t [NPT-1:0] data_q, data_d;
  logic            mode_q, mode_d;
  logic            full_q, full_d;
  logic [IDXW-1:0] wr_addr_s;

`ifdef FFT_FRAME_LOADER_BITREV_EN
  assign wr_addr_s = bitrev3(wr_idx_i);
`else
  assign wr_addr_s = wr_idx_i;
`endif

  // Next-state for storage, mode latch and full flag.
  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    full_d = full_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (wr_en_i && wr_last_i) begin
      full_d = 1'b1;
    end else begin
      full_d = full_q;
    end
    if (wr_en_i) begin
      data_d[wr_addr_s] = wr_data_i;
      mode_d = (wr_idx_i == {IDXW{1'b0}}) ? wr_mode_i : mode_q;
    end else begin
      data_d = data_q;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      mode_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign mode_o = mode_q;
  assign full_o = full_q;
endmodule

// File: rtl/fft_frame_loader.sv
// Packs a serial complex stream into 8-point frames through two ping-pong banks.
// Optional bit-reversed output order: FFT_FRAME_LOADER_BITREV_EN.
module fft_frame_loader
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fft_frame_loader_if.slave  bus
);
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [IDXW-1:0]        wr_idx_q, wr_idx_d;
  logic                   out_valid_q, out_valid_d;
  logic [NPT-1:0][DW-1:0] out_r_q, out_r_d;
  logic [NPT-1:0][DW-1:0] out_i_q, out_i_d;
  logic                   out_mode_q, out_mode_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic [1:0]             bank_full_s;
  logic [1:0]             bank_mode_s;
  cplx_t [NPT-1:0]        bank_data_s [2];
  cplx_t [NPT-1:0]        rd_data_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   wr_en_s;
  logic                   last_s;
  logic                   xfer_s;

  // in_ready depends only on registered bank state, never on out_ready.
  assign in_ready_s = !bank_full_s[wr_bank_q];
  assign accept_s   = bus.in_valid && in_ready_s;
  assign wr_en_s    = accept_s && !bus.frame_abort;
  assign last_s     = (wr_idx_q == 3'd7);
  assign xfer_s     = bank_full_s[rd_bank_q] && (!out_valid_q || bus.out_ready);
  assign rd_data_s  = bank_data_s[rd_bank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en_s && (wr_bank_q == 1'(b))),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (cplx_t'{r: bus.in_r, i: bus.in_i}),
      .wr_mode_i (bus.in_mode),
      .wr_last_i (last_s),
      .clr_i     (xfer_s && (rd_bank_q == 1'(b))),
      .data_o    (bank_data_s[b]),
      .mode_o    (bank_mode_s[b]),
      .full_o    (bank_full_s[b])
    );
  end

  // Write pointer, read pointer and output register next-state.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_mode_d  = out_mode_q;
    frame_cnt_d = frame_cnt_q;

    if (bus.frame_abort) begin
      wr_idx_d = 3'd0;
    end else if (accept_s && last_s) begin
      wr_idx_d  = 3'd0;
      wr_bank_d = !wr_bank_q;
    end else if (accept_s) begin
      wr_idx_d = wr_idx_q + 3'd1;
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (xfer_s) begin
      for (int k = 0; k < NPT; k++) begin
        out_r_d[k] = rd_data_s[k].r;
        out_i_d[k] = rd_data_s[k].i;
      end
      out_mode_d  = bank_mode_s[rd_bank_q];
      out_valid_d = 1'b1;
      rd_bank_d   = !rd_bank_q;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx_q    <= 3'd0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_mode_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_mode_q  <= out_mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream stage of fft_8pt: packs a serial stream of complex Q3.12 samples (16-bit signed, 1.0 = 16'h1000) into 8-point frames.
- Presents each frame on fft_8pt's 8 parallel real/imag inputs, together with the per-frame mode bit.
- Ping-pong buffering lets input keep streaming while a frame is held for the consumer; valid/ready on both sides.

Parameters:
- NPT, 8, points per frame (fixed at 8; index width 3)
- DW, 16, sample width per real/imag component (signed Q3.12)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  serial sample valid
- in_ready  out  1  loader can accept a sample
- in_r  in  DW  sample real part, signed
- in_i  in  DW  sample imaginary part, signed
- in_mode  in  1  0=FFT, 1=IFFT; sampled with the first sample (index 0) of each frame
- frame_abort  in  1  synchronous discard of the partially filled frame
- out_valid  out  1  frame present on out_r/out_i
- out_ready  in  1  consumer takes frame (tie 1 for free-running fft_8pt)
- out_r  out  NPT x DW  packed array, element k = real part of sample k
- out_i  out  NPT x DW  packed array, element k = imaginary part of sample k
- out_mode  out  1  mode bit of the presented frame
- frame_cnt  out  16  frames delivered since reset, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, active-high): all outputs 0 except in_ready=1. Both banks empty, wr_bank=rd_bank=0, wr_idx=0, frame_cnt=0. Reset mid-frame discards everything; no partial frame is ever emitted.
- Storage: two banks (A/B). Each bank holds 8 complex entries, 1 mode bit and a full flag.
- in_ready = !full[wr_bank], registered-state derived with no combinational path from out_ready.
- Accept when in_valid && in_ready:
  - Write to bank[wr_bank][wr_idx]; wr_idx increments.
  - At wr_idx==0, latch in_mode into the bank.
  - On wr_idx==7: set full[wr_bank], toggle wr_bank, wr_idx returns to 0.
- Transfer when full[rd_bank] && (!out_valid || out_ready):
  - Load out_r/out_i/out_mode from the bank; set out_valid=1.
  - Clear full[rd_bank], toggle rd_bank, increment frame_cnt.
- If out_valid && out_ready and no full bank: out_valid falls. Data holds its last value and is not cleared.
- Latency: out_valid rises after the clock edge following the edge that accepts sample 7. With out_ready=1 and continuous input, throughput is 1 frame per 8 cycles with no bubbles.
- Backpressure: out_valid && !out_ready holds out_* stable. Both banks may fill (16 buffered samples + 1 held frame); then in_ready=0 until a transfer frees a bank.
- frame_abort: wr_idx resets to 0 and the partial data is ignored. Full banks and the output register are unaffected. An abort concurrent with an accept drops that sample too. An abort coinciding with the 7th-index accept prevails (frame not marked full).
- Set/clear of full never targets the same bank on the same edge: set targets the filling bank, clear targets a bank already full.
- No arithmetic, no saturation; data passes bit-exact.

Optional Feature:
- Macro: FFT_FRAME_LOADER_BITREV_EN.
- Defined: out_r[k]/out_i[k] carry the sample with input index bitrev3(k) (order 0,4,2,6,1,5,3,7), for decimation-in-time cores expecting bit-reversed input. The permutation is applied at bank write; latency is unchanged.
- Undefined: natural order, out[k] = sample k.

Decomposition:
- fft_pkg holds:
  - localparam NPT=8, DW=16, IDXW=3
  - typedef cplx_t (struct packed: signed [DW-1:0] r, i)
  - function bitrev3
  - localparam Q_ONE=16'h1000
- One sub-module, fft_frame_bank: 8 x cplx_t storage + mode + full flag, with write port (idx, data, last) and clear. Instantiated twice; the top holds pointers, wr_idx, output register and frame_cnt.

Test Plan:
- Reset, then 8 accepted samples r=k*16'h1000, i=-k*16'h0800 (k=0..7), out_ready=1 -> out_valid rises 1 cycle after the 8th accept for exactly 1 cycle; out_r[3]=16'h3000, out_i[3]=16'hE800; frame_cnt=1.
- Continuous 32 samples with out_ready=1, in_mode=1 for frames 1 and 3 -> 4 frames 8 cycles apart; in_ready never low; out_mode pattern 0,1,0,1 (frames numbered 0..3).
- out_ready=0, stream 24 samples -> in_ready falls after the 24th accept; out_* stable. Raise out_ready -> frames emitted in order; in_ready returns 1 cycle after the first transfer.
- 5 samples, frame_abort, then 8 samples value 16'h0100 -> exactly one frame, all out_r=16'h0100; frame_cnt=1.
- Assert reset asynchronously mid-frame (between clock edges, 4 samples in) -> outputs immediately 0, in_ready=1; the next 8 samples form frame 0.
- With FFT_FRAME_LOADER_BITREV_EN, input r=k -> out_r = {0,4,2,6,1,5,3,7}; without it, out_r[k]=k.
